// File: rtl/rob_pkg.sv
// Shared constants and the entry record for the reorder buffer.
package rob_pkg;

  localparam int RoB_WIDTH    = 8;
  localparam int RoB_SIZE     = 1 << RoB_WIDTH;
  localparam int EX_REG_WIDTH = 6;

  // Destination code for instructions that write no architectural register.
  localparam logic [EX_REG_WIDTH-1:0] NON_REG = 6'b100000;
  // Tag meaning "operand has no pending producer in the buffer".
  localparam logic [RoB_WIDTH:0] NON_DEP = {1'b1, {RoB_WIDTH{1'b0}}};

  typedef struct packed {
    logic                    busy;
    logic                    ready;
    logic [EX_REG_WIDTH-1:0] rd;
    logic [31:0]             value;
    logic                    is_branch;
    logic                    pred_taken;
    logic                    taken;
    logic [31:0]             pc;
    logic [31:0]             target;
  } rob_entry_t;

  // Fetch restart address for a resolved branch; pc+4 wraps at 32 bits.
  function automatic logic [31:0] redirect_pc(input logic        taken,
                                              input logic [31:0] pc,
                                              input logic [31:0] target);
    return taken ? target : pc + 32'd4;
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatcher / CDB / register-file / fetch signals of the reorder buffer.
// Dispatch handshake: DPRoB_en is a request that is accepted at a clock edge
// only when RoBDP_full is low, Sys_rdy is high and no flush happens that
// cycle; an unaccepted request must be held by the Dispatcher. The accepted
// entry receives the RoBDP_tail index seen during that cycle.
interface reorder_buffer_if;
  import rob_pkg::*;

  logic                    DPRoB_en;
  logic [EX_REG_WIDTH-1:0] DPRoB_rd;
  logic                    DPRoB_is_branch;
  logic                    DPRoB_pred_taken;
  logic [31:0]             DPRoB_pc;
  logic                    RoBDP_full;
  logic [RoB_WIDTH-1:0]    RoBDP_tail;

  logic                    CDBRoB_en;
  logic [RoB_WIDTH-1:0]    CDBRoB_index;
  logic [31:0]             CDBRoB_value;
  logic                    CDBRoB_taken;
  logic [31:0]             CDBRoB_target;

  logic                    RoBRF_en;
  logic [RoB_WIDTH-1:0]    RoBRF_RoB_index;
  logic [EX_REG_WIDTH-1:0] RoBRF_rd;
  logic [31:0]             RoBRF_value;
  logic                    RoBRF_pre_judge;
  logic                    RoBIF_redirect;
  logic [31:0]             RoBIF_pc;

  modport master (
    output DPRoB_en, DPRoB_rd, DPRoB_is_branch, DPRoB_pred_taken, DPRoB_pc,
    output CDBRoB_en, CDBRoB_index, CDBRoB_value, CDBRoB_taken, CDBRoB_target,
    input  RoBDP_full, RoBDP_tail,
    input  RoBRF_en, RoBRF_RoB_index, RoBRF_rd, RoBRF_value, RoBRF_pre_judge,
    input  RoBIF_redirect, RoBIF_pc
  );

  modport slave (
    input  DPRoB_en, DPRoB_rd, DPRoB_is_branch, DPRoB_pred_taken, DPRoB_pc,
    input  CDBRoB_en, CDBRoB_index, CDBRoB_value, CDBRoB_taken, CDBRoB_target,
    output RoBDP_full, RoBDP_tail,
    output RoBRF_en, RoBRF_RoB_index, RoBRF_rd, RoBRF_value, RoBRF_pre_judge,
    output RoBIF_redirect, RoBIF_pc
  );

endinterface

// File: rtl/rob_commit_ctrl.sv
// Head-entry retirement: decides commit vs. mispredict flush and registers
// the RoBRF_* commit and RoBIF_* redirect outputs (single-cycle pulses).
module rob_commit_ctrl
  import rob_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    nonempty,
  input  rob_entry_t              head_entry,
  input  logic [RoB_WIDTH-1:0]    head_idx,
  output logic                    retire,
  output logic                    flush,
  output logic                    rf_en,
  output logic [RoB_WIDTH-1:0]    rf_idx,
  output logic [EX_REG_WIDTH-1:0] rf_rd,
  output logic [31:0]             rf_value,
  output logic                    pre_judge,
  output logic                    redirect,
  output logic [31:0]             redirect_addr
);

  logic                    rf_en_d,     rf_en_q;
  logic [RoB_WIDTH-1:0]    rf_idx_d,    rf_idx_q;
  logic [EX_REG_WIDTH-1:0] rf_rd_d,     rf_rd_q;
  logic [31:0]             rf_value_d,  rf_value_q;
  logic                    pre_judge_d, pre_judge_q;
  logic                    redirect_d,  redirect_q;
  logic [31:0]             pc_d,        pc_q;
  logic                    mispred;

  // Retirement decision and next values of the registered outputs; data
  // fields hold between commits, strobes fall back to idle every enabled cycle.
  always_comb begin
    mispred     = head_entry.is_branch && (head_entry.taken != head_entry.pred_taken);
    retire      = rdy && nonempty && head_entry.busy && head_entry.ready;
    flush       = retire && mispred;
    rf_en_d     = rf_en_q;
    rf_idx_d    = rf_idx_q;
    rf_rd_d     = rf_rd_q;
    rf_value_d  = rf_value_q;
    pre_judge_d = pre_judge_q;
    redirect_d  = redirect_q;
    pc_d        = pc_q;
    if (rdy) begin
      rf_en_d     = 1'b0;
      pre_judge_d = 1'b1;
      redirect_d  = 1'b0;
      if (flush) begin
        pre_judge_d = 1'b0;
        redirect_d  = 1'b1;
        pc_d        = redirect_pc(head_entry.taken, head_entry.pc, head_entry.target);
      end else if (retire) begin
        rf_en_d    = 1'b1;
        rf_idx_d   = head_idx;
        rf_rd_d    = head_entry.is_branch ? NON_REG : head_entry.rd;
        rf_value_d = head_entry.value;
      end
    end
  end

  // Output registers with their reset values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_en_q     <= 1'b0;
      rf_idx_q    <= '0;
      rf_rd_q     <= NON_REG;
      rf_value_q  <= '0;
      pre_judge_q <= 1'b1;
      redirect_q  <= 1'b0;
      pc_q        <= '0;
    end else begin
      rf_en_q     <= rf_en_d;
      rf_idx_q    <= rf_idx_d;
      rf_rd_q     <= rf_rd_d;
      rf_value_q  <= rf_value_d;
      pre_judge_q <= pre_judge_d;
      redirect_q  <= redirect_d;
      pc_q        <= pc_d;
    end
  end

  assign rf_en         = rf_en_q;
  assign rf_idx        = rf_idx_q;
  assign rf_rd         = rf_rd_q;
  assign rf_value      = rf_value_q;
  assign pre_judge     = pre_judge_q;
  assign redirect      = redirect_q;
  assign redirect_addr = pc_q;

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocation from the Dispatcher, result capture from
// the CDB, in-order retirement with branch-mispredict flush.
// Optional macro ROB_PERF_CNT_EN adds saturating commit/mispredict counters.
module reorder_buffer
  import rob_pkg::*;
(
  input  logic              Sys_clk,
  input  logic              Sys_rst,
  input  logic              Sys_rdy,
`ifdef ROB_PERF_CNT_EN
  output logic [31:0]       RoBPerf_commits,
  output logic [31:0]       RoBPerf_mispred,
`endif
  reorder_buffer_if.slave   rob
);

  rob_entry_t             entries_d [RoB_SIZE];
  rob_entry_t             entries_q [RoB_SIZE];
  logic [RoB_WIDTH-1:0]   head_d,  head_q;
  logic [RoB_WIDTH-1:0]   tail_d,  tail_q;
  logic [RoB_WIDTH:0]     count_d, count_q;
  logic                   full, alloc, wb, retire, flush;

  rob_commit_ctrl u_commit (
    .clk           (Sys_clk),
    .rst           (Sys_rst),
    .rdy           (Sys_rdy),
    .nonempty      (count_q != '0),
    .head_entry    (entries_q[head_q]),
    .head_idx      (head_q),
    .retire        (retire),
    .flush         (flush),
    .rf_en         (rob.RoBRF_en),
    .rf_idx        (rob.RoBRF_RoB_index),
    .rf_rd         (rob.RoBRF_rd),
    .rf_value      (rob.RoBRF_value),
    .pre_judge     (rob.RoBRF_pre_judge),
    .redirect      (rob.RoBIF_redirect),
    .redirect_addr (rob.RoBIF_pc)
  );

  // Entry array, pointer and occupancy update; a flush overrides allocate and
  // write-back, and write-back lands before the head is released.
  always_comb begin
    full      = (count_q == (RoB_WIDTH+1)'(RoB_SIZE));
    alloc     = Sys_rdy && rob.DPRoB_en && !full && !flush;
    wb        = Sys_rdy && rob.CDBRoB_en && entries_q[rob.CDBRoB_index].busy && !flush;
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (flush) begin
      for (int i = 0; i < RoB_SIZE; i++) begin
        entries_d[i].busy  = 1'b0;
        entries_d[i].ready = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wb) begin
        entries_d[rob.CDBRoB_index].ready  = 1'b1;
        entries_d[rob.CDBRoB_index].value  = rob.CDBRoB_value;
        entries_d[rob.CDBRoB_index].taken  = rob.CDBRoB_taken;
        entries_d[rob.CDBRoB_index].target = rob.CDBRoB_target;
      end
      if (retire) begin
        entries_d[head_q].busy  = 1'b0;
        entries_d[head_q].ready = 1'b0;
        head_d = head_q + 1'b1;
      end
      if (alloc) begin
        entries_d[tail_q] = '{busy: 1'b1, ready: 1'b0, rd: rob.DPRoB_rd, value: '0,
                              is_branch: rob.DPRoB_is_branch,
                              pred_taken: rob.DPRoB_pred_taken, taken: 1'b0,
                              pc: rob.DPRoB_pc, target: '0};
        tail_d = tail_q + 1'b1;
      end
      if (alloc && !retire) begin
        count_d = count_q + 1'b1;
      end else if (!alloc && retire) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Buffer state registers.
  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      for (int i = 0; i < RoB_SIZE; i++) begin
        entries_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  assign rob.RoBDP_full = full;
  assign rob.RoBDP_tail = tail_q;

`ifdef ROB_PERF_CNT_EN
  logic [31:0] commits_d, commits_q, mispred_d, mispred_q;

  // Saturating event counters; events only occur while Sys_rdy is high.
  always_comb begin
    commits_d = commits_q;
    mispred_d = mispred_q;
    if (retire && !flush && commits_q != 32'hFFFF_FFFF) commits_d = commits_q + 32'd1;
    if (flush && mispred_q != 32'hFFFF_FFFF)            mispred_d = mispred_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      commits_q <= '0;
      mispred_q <= '0;
    end else begin
      commits_q <= commits_d;
      mispred_q <= mispred_d;
    end
  end

  assign RoBPerf_commits = commits_q;
  assign RoBPerf_mispred = mispred_q;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: reset, commit path, full/wrap,
// out-of-order write-back, mispredict flush, Sys_rdy hold and mid-run reset.
module tb_reorder_buffer;
  import rob_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  reorder_buffer_if rob_bus ();

  reorder_buffer dut (
    .Sys_clk (clk),
    .Sys_rst (rst),
    .Sys_rdy (rdy),
    .rob     (rob_bus)
  );

  // Clock and a watchdog so the run always ends.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic dispatch(input logic [5:0] rd, input logic br, input logic pred,
                          input logic [31:0] pc);
    rob_bus.DPRoB_en         = 1'b1;
    rob_bus.DPRoB_rd         = rd;
    rob_bus.DPRoB_is_branch  = br;
    rob_bus.DPRoB_pred_taken = pred;
    rob_bus.DPRoB_pc         = pc;
    tick();
    rob_bus.DPRoB_en         = 1'b0;
  endtask

  task automatic writeback(input logic [7:0] idx, input logic [31:0] val,
                           input logic taken, input logic [31:0] target);
    rob_bus.CDBRoB_en     = 1'b1;
    rob_bus.CDBRoB_index  = idx;
    rob_bus.CDBRoB_value  = val;
    rob_bus.CDBRoB_taken  = taken;
    rob_bus.CDBRoB_target = target;
    tick();
    rob_bus.CDBRoB_en     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rf_en"},  32'(rob_bus.RoBRF_en), 32'd0);
    check({tag, "_rf_idx"}, 32'(rob_bus.RoBRF_RoB_index), 32'd0);
    check({tag, "_rf_rd"},  32'(rob_bus.RoBRF_rd), 32'h20);
    check({tag, "_rf_val"}, rob_bus.RoBRF_value, 32'd0);
    check({tag, "_pre"},    32'(rob_bus.RoBRF_pre_judge), 32'd1);
    check({tag, "_redir"},  32'(rob_bus.RoBIF_redirect), 32'd0);
    check({tag, "_if_pc"},  rob_bus.RoBIF_pc, 32'd0);
    check({tag, "_full"},   32'(rob_bus.RoBDP_full), 32'd0);
    check({tag, "_tail"},   32'(rob_bus.RoBDP_tail), 32'd0);
  endtask

  // Directed stimulus and checks.
  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    rob_bus.DPRoB_en = 1'b0;  rob_bus.DPRoB_rd = '0;  rob_bus.DPRoB_is_branch = 1'b0;
    rob_bus.DPRoB_pred_taken = 1'b0;  rob_bus.DPRoB_pc = '0;
    rob_bus.CDBRoB_en = 1'b0;  rob_bus.CDBRoB_index = '0;  rob_bus.CDBRoB_value = '0;
    rob_bus.CDBRoB_taken = 1'b0;  rob_bus.CDBRoB_target = '0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single instruction: dispatch, write-back, commit.
    dispatch(6'd5, 1'b0, 1'b0, 32'h0);
    check("t1_tail", 32'(rob_bus.RoBDP_tail), 32'd1);
    writeback(8'd0, 32'hDEADBEEF, 1'b0, 32'h0);
    check("t1_no_bypass", 32'(rob_bus.RoBRF_en), 32'd0);
    tick();
    check("t1_rf_en",  32'(rob_bus.RoBRF_en), 32'd1);
    check("t1_rf_idx", 32'(rob_bus.RoBRF_RoB_index), 32'd0);
    check("t1_rf_rd",  32'(rob_bus.RoBRF_rd), 32'd5);
    check("t1_rf_val", rob_bus.RoBRF_value, 32'hDEADBEEF);
    check("t1_pre",    32'(rob_bus.RoBRF_pre_judge), 32'd1);
    tick();
    check("t1_pulse",  32'(rob_bus.RoBRF_en), 32'd0);

    // Fill all 256 entries, refuse the 257th, free one by commit.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      dispatch(6'(i % 32), 1'b0, 1'b0, 32'(i * 4));
    end
    check("fill_full", 32'(rob_bus.RoBDP_full), 32'd1);
    check("fill_tail", 32'(rob_bus.RoBDP_tail), 32'd0);
    dispatch(6'd9, 1'b0, 1'b0, 32'h400);
    check("over_full", 32'(rob_bus.RoBDP_full), 32'd1);
    check("over_tail", 32'(rob_bus.RoBDP_tail), 32'd0);
    writeback(8'd0, 32'h11, 1'b0, 32'h0);
    check("fill_wb_en", 32'(rob_bus.RoBRF_en), 32'd0);
    tick();
    check("fill_rf_en",  32'(rob_bus.RoBRF_en), 32'd1);
    check("fill_rf_idx", 32'(rob_bus.RoBRF_RoB_index), 32'd0);
    check("fill_rf_val", rob_bus.RoBRF_value, 32'h11);
    check("fill_unfull", 32'(rob_bus.RoBDP_full), 32'd0);
    check("fill_wrap",   32'(rob_bus.RoBDP_tail), 32'd0);
    dispatch(6'd9, 1'b0, 1'b0, 32'h400);
    check("refill_full", 32'(rob_bus.RoBDP_full), 32'd1);
    check("refill_tail", 32'(rob_bus.RoBDP_tail), 32'd1);

    // Out-of-order write-back, in-order commit on consecutive cycles.
    do_reset();
    dispatch(6'd1, 1'b0, 1'b0, 32'h10);
    dispatch(6'd2, 1'b0, 1'b0, 32'h14);
    dispatch(6'd3, 1'b0, 1'b0, 32'h18);
    writeback(8'd2, 32'hA2, 1'b0, 32'h0);
    writeback(8'd1, 32'hA1, 1'b0, 32'h0);
    writeback(8'd0, 32'hA0, 1'b0, 32'h0);
    check("ooo_wait", 32'(rob_bus.RoBRF_en), 32'd0);
    exp_q.push_back(32'hA0);
    exp_q.push_back(32'hA1);
    exp_q.push_back(32'hA2);
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_v = exp_q.pop_front();
      check("ooo_rf_en",  32'(rob_bus.RoBRF_en), 32'd1);
      check("ooo_rf_idx", 32'(rob_bus.RoBRF_RoB_index), 32'(k));
      check("ooo_rf_rd",  32'(rob_bus.RoBRF_rd), 32'(k + 1));
      check("ooo_rf_val", rob_bus.RoBRF_value, exp_v);
    end
    tick();
    check("ooo_done", 32'(rob_bus.RoBRF_en), 32'd0);

    // Mispredict (predicted not-taken, actually taken) with a same-cycle allocate.
    do_reset();
    dispatch(NON_REG, 1'b1, 1'b0, 32'h100);
    writeback(8'd0, 32'h0, 1'b1, 32'h200);
    dispatch(6'd7, 1'b0, 1'b0, 32'h300);
    check("mp1_pre",   32'(rob_bus.RoBRF_pre_judge), 32'd0);
    check("mp1_rf_en", 32'(rob_bus.RoBRF_en), 32'd0);
    check("mp1_redir", 32'(rob_bus.RoBIF_redirect), 32'd1);
    check("mp1_if_pc", rob_bus.RoBIF_pc, 32'h200);
    check("mp1_tail",  32'(rob_bus.RoBDP_tail), 32'd0);
    check("mp1_full",  32'(rob_bus.RoBDP_full), 32'd0);
    tick();
    check("mp1_pre_pulse",   32'(rob_bus.RoBRF_pre_judge), 32'd1);
    check("mp1_redir_pulse", 32'(rob_bus.RoBIF_redirect), 32'd0);
    writeback(8'd0, 32'h99, 1'b0, 32'h0);
    tick();
    check("mp1_dropped", 32'(rob_bus.RoBRF_en), 32'd0);

    // Mispredict (predicted taken, actually not-taken) redirects to pc+4.
    dispatch(NON_REG, 1'b1, 1'b1, 32'h100);
    writeback(8'd0, 32'h0, 1'b0, 32'h300);
    tick();
    check("mp2_redir", 32'(rob_bus.RoBIF_redirect), 32'd1);
    check("mp2_if_pc", rob_bus.RoBIF_pc, 32'h104);
    check("mp2_pre",   32'(rob_bus.RoBRF_pre_judge), 32'd0);
    tick();

    // Correctly predicted branch commits with rd forced to NON_REG.
    dispatch(6'd9, 1'b1, 1'b1, 32'h40);
    writeback(8'd0, 32'h55, 1'b1, 32'h80);
    tick();
    check("br_rf_en",  32'(rob_bus.RoBRF_en), 32'd1);
    check("br_rf_rd",  32'(rob_bus.RoBRF_rd), 32'(NON_REG));
    check("br_rf_idx", 32'(rob_bus.RoBRF_RoB_index), 32'd0);
    check("br_redir",  32'(rob_bus.RoBIF_redirect), 32'd0);
    check("br_pre",    32'(rob_bus.RoBRF_pre_judge), 32'd1);

    // Sys_rdy low freezes commit and allocation; outputs hold.
    dispatch(6'd4, 1'b0, 1'b0, 32'h44);
    writeback(8'd1, 32'h77, 1'b0, 32'h0);
    rdy = 1'b0;
    rob_bus.DPRoB_en = 1'b1;
    rob_bus.DPRoB_rd = 6'd8;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_rf_en", 32'(rob_bus.RoBRF_en), 32'd0);
      check("hold_tail",  32'(rob_bus.RoBDP_tail), 32'd2);
    end
    rob_bus.DPRoB_en = 1'b0;
    rdy = 1'b1;
    tick();
    check("rdy_rf_en",  32'(rob_bus.RoBRF_en), 32'd1);
    check("rdy_rf_idx", 32'(rob_bus.RoBRF_RoB_index), 32'd1);
    check("rdy_rf_rd",  32'(rob_bus.RoBRF_rd), 32'd4);
    check("rdy_rf_val", rob_bus.RoBRF_value, 32'h77);
    rdy = 1'b0;
    tick();
    check("hold_pulse", 32'(rob_bus.RoBRF_en), 32'd1);
    rdy = 1'b1;
    tick();
    check("pulse_end", 32'(rob_bus.RoBRF_en), 32'd0);

    // Reset with a ready head discards everything.
    dispatch(6'd12, 1'b0, 1'b0, 32'h50);
    dispatch(6'd13, 1'b0, 1'b0, 32'h54);
    writeback(8'd2, 32'hAB, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    tick();
    check("midrst_no_commit", 32'(rob_bus.RoBRF_en), 32'd0);
    tick();
    check("midrst_no_commit2", 32'(rob_bus.RoBRF_en), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
